jtframe_joyser: RTL

- Parametrised serial-joystick scanner, successor to the fixed two-player DB15 reader used by the MiSTer framework top level.
- Drives an external parallel-in/serial-out shift-register chain through a clock/load pair and de-serialises PLAYERS×BITS bits per scan.
- Optionally debounces each scan, and publishes per-player active-high joystick words plus a connection flag.
- Sits between the board pins (JOY_CLK/JOY_LOAD/JOY_DATA) and the joystick muxing logic ahead of jtframe_board.

---
 rtl/jtframe_joyser_pkg.sv | 20 ++
 rtl/jtframe_joyser_if.sv | 23 ++
 rtl/jtframe_joyser_tick.sv | 24 ++
 rtl/jtframe_joyser.sv | 132 +++++++++++++
 4 files changed

// File: rtl/jtframe_joyser_pkg.sv
// Shared types and constants for the serial joystick scanner.
package jtframe_joyser_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_LOAD    = 3'd1;
    localparam state_t S_SHIFT_L = 3'd2;
    localparam state_t S_SHIFT_H = 3'd3;
    localparam state_t S_LATCH   = 3'd4;

    // An unplugged player's line floats high, so its raw word reads all ones.
    localparam logic [15:0] ABSENT_WORD = 16'hFFFF;

    // Ticks from the load strobe to the end of the latch tick.
    function automatic int scan_ticks(input int players, input int bits);
        return 2 + 2 * players * bits;
    endfunction

endpackage

// File: rtl/jtframe_joyser_if.sv
// Pin-side and published-data signals of the joystick scanner.
interface jtframe_joyser_if #(
    parameter int PLAYERS = 2,
    parameter int BITS    = 16
);
    logic                      enable;
    logic                      joy_clk;
    logic                      joy_load;
    logic                      joy_data;
    logic [PLAYERS*BITS-1:0]   joystick;
    logic [PLAYERS-1:0]        present;
    logic                      scan_done;

    modport master (
        input  enable, joy_data,
        output joy_clk, joy_load, joystick, present, scan_done
    );

    modport slave (
        output enable, joy_data,
        input  joy_clk, joy_load, joystick, present, scan_done
    );
endinterface

// File: rtl/jtframe_joyser_tick.sv
// Free-running divider: one-clk tick strobe every DIV clocks.
module jtframe_joyser_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/jtframe_joyser.sv
// Serial joystick scanner: drives a PISO chain, de-serialises it and
// publishes per-player words with optional two-scan debounce.
module jtframe_joyser
    import jtframe_joyser_pkg::*;
#(
    parameter int PLAYERS  = 2,
    parameter int BITS     = 16,
    parameter int DIV      = 4,
    parameter int GAP      = 64,
    parameter int INVERT   = 1,
    parameter int DEBOUNCE = 1
) (
    input  logic clk,
    input  logic rst,
    jtframe_joyser_if.master bus
);
    localparam int NB = (scan_ticks(PLAYERS, BITS) - 2) / 2;
    localparam int NW = $clog2(NB);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    logic              w_tick;
    logic              w_publish;
    logic [PLAYERS-1:0] w_absent;
    logic [NB-1:0]     w_next_joy;

    state_t            r_state;
    logic [NW-1:0]     r_bit;
    logic [GW-1:0]     r_gap;
    logic [1:0]        r_sync;
    logic [NB-1:0]     r_buf;
    logic [NB-1:0]     r_prev;
    logic              r_valid;
    logic [NB-1:0]     r_joy;
    logic [PLAYERS-1:0] r_present;
    logic              r_jclk;
    logic              r_jload;
    logic              r_done;

    jtframe_joyser_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // r_valid keeps the first scan after reset from matching the cleared history.
    assign w_publish = (DEBOUNCE == 0) || (r_valid && (r_buf == r_prev));

    genvar gi;
    generate
        for (gi = 0; gi < PLAYERS; gi++) begin : g_player
            logic [BITS-1:0] w_raw;
            assign w_raw = (INVERT != 0) ? ~r_buf[gi*BITS +: BITS] : r_buf[gi*BITS +: BITS];
            assign w_absent[gi] = (w_raw == ABSENT_WORD[BITS-1:0]);
            assign w_next_joy[gi*BITS +: BITS] = w_absent[gi] ? '0 :
                   (w_publish ? r_buf[gi*BITS +: BITS] : r_joy[gi*BITS +: BITS]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit     <= '0;
            r_gap     <= '0;
            r_sync    <= 2'b11;
            r_buf     <= '0;
            r_prev    <= '0;
            r_valid   <= 1'b0;
            r_joy     <= '0;
            r_present <= '0;
            r_jclk    <= 1'b1;
            r_jload   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], bus.joy_data};
            r_done <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    S_IDLE: begin
                        r_jclk  <= 1'b1;
                        r_jload <= 1'b1;
                        if (!bus.enable) begin
                            r_gap <= '0;
                        end else if (r_gap == GW'(GAP - 1)) begin
                            r_gap   <= '0;
                            r_jload <= 1'b0;
                            r_state <= S_LOAD;
                        end else begin
                            r_gap <= r_gap + GW'(1);
                        end
                    end
                    S_LOAD: begin
                        r_jload <= 1'b1;
                        r_jclk  <= 1'b0;
                        r_state <= S_SHIFT_L;
                    end
                    S_SHIFT_L: begin
                        // Sampled at the end of the low phase so the synchroniser has settled.
                        r_buf[r_bit] <= (INVERT != 0) ? ~r_sync[1] : r_sync[1];
                        r_jclk       <= 1'b1;
                        r_state      <= S_SHIFT_H;
                    end
                    S_SHIFT_H: begin
                        if (r_bit == NW'(NB - 1)) begin
                            r_bit   <= '0;
                            r_state <= S_LATCH;
                        end else begin
                            r_bit   <= r_bit + NW'(1);
                            r_jclk  <= 1'b0;
                            r_state <= S_SHIFT_L;
                        end
                    end
                    S_LATCH: begin
                        r_joy     <= w_next_joy;
                        r_present <= ~w_absent;
                        r_prev    <= r_buf;
                        r_valid   <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.joy_clk   = r_jclk;
    assign bus.joy_load  = r_jload;
    assign bus.joystick  = r_joy;
    assign bus.present   = r_present;
    assign bus.scan_done = r_done;

endmodule
